// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo read-port slice: default sizes, the
// sequence-checker state type and a pointer-width helper.
package fifo_pkg;

   localparam int FIFO_WIDTH = 6;
   localparam int FIFO_DEPTH = 64;

   typedef enum logic {
      CHK_IDLE  = 1'b0,
      CHK_TRACK = 1'b1
   } chk_state_e;

   // Pointer width for an n-entry buffer, never less than one bit.
   function automatic int clog2_min1(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_rd_port_if.sv
// Handshake bundle of the read port: fifo read side (empty/read/out_vld/out_data)
// and the downstream valid/ready stream. master = the read port itself.
interface fifo_rd_port_if import fifo_pkg::*; #(
   parameter int WIDTH = FIFO_WIDTH
) ();

   logic             empty_i;
   logic             read_o;
   logic             out_vld_i;
   logic [WIDTH-1:0] out_data_i;
   logic             m_vld_o;
   logic [WIDTH-1:0] m_data_o;
   logic             m_rdy_i;

   modport master (
      input  empty_i, out_vld_i, out_data_i, m_rdy_i,
      output read_o, m_vld_o, m_data_o
   );

   modport slave (
      output empty_i, out_vld_i, out_data_i, m_rdy_i,
      input  read_o, m_vld_o, m_data_o
   );

endinterface

// File: rtl/fifo_rd_skid.sv
// Circular skid buffer absorbing words that arrive from the fifo read pipe.
// A push while full is accepted only when a pop frees the head slot in the
// same cycle; otherwise the word is dropped (the caller flags that case).
module fifo_rd_skid import fifo_pkg::*; #(
   parameter int WIDTH = FIFO_WIDTH,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic [$clog2(DEPTH+1)-1:0] occ,
   output logic                       full,
   output logic                       empty
);

   localparam int PTR_W = clog2_min1(DEPTH);
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [OCC_W-1:0] occ_r;
   logic             wr_en_s;
   logic             rd_en_s;
   logic             full_s;
   logic             empty_s;

   // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two).
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : (p + PTR_W'(1'b1));
   endfunction

   // Status flags and qualified write/read enables.
   always_comb begin
      full_s  = (occ_r == OCC_W'(DEPTH));
      empty_s = (occ_r == {OCC_W{1'b0}});
      wr_en_s = push & (~full_s | pop);
      rd_en_s = pop & ~empty_s;
   end

   // Storage, pointers and occupancy; all cleared by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         occ_r    <= {OCC_W{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else begin
         if (wr_en_s) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= next_ptr(wr_ptr_r);
         end
         if (rd_en_s) begin
            rd_ptr_r <= next_ptr(rd_ptr_r);
         end
         case ({wr_en_s, rd_en_s})
            2'b10:   occ_r <= occ_r + OCC_W'(1'b1);
            2'b01:   occ_r <= occ_r - OCC_W'(1'b1);
            default: occ_r <= occ_r;
         endcase
      end
   end

   assign head  = mem_r[rd_ptr_r];
   assign occ   = occ_r;
   assign full  = full_s;
   assign empty = empty_s;

endmodule

// File: rtl/fifo_rd_port.sv
// Fifo read port: issues credit-limited pops, buffers returning words in a
// skid buffer and re-presents them on a valid/ready stream. Also counts
// delivered words and checks an incrementing data pattern.
module fifo_rd_port import fifo_pkg::*; #(
   parameter int WIDTH      = FIFO_WIDTH,
   parameter int RD_LAT     = 1,
   parameter int SKID_DEPTH = 2,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   fifo_rd_port_if.master   bus,
   input  logic             chk_en_i,
   output logic             seq_err_o,
   output logic             proto_err_o,
   output logic [CNT_W-1:0] word_cnt_o
);

   localparam int OCC_W = $clog2(SKID_DEPTH + 1);

   if ((RD_LAT < 1) || (RD_LAT > 4)) begin : g_bad_lat
      $error("fifo_rd_port: RD_LAT must be in 1..4");
   end
   if (SKID_DEPTH < (RD_LAT + 1)) begin : g_bad_skid
      $error("fifo_rd_port: SKID_DEPTH must be >= RD_LAT+1");
   end

   logic [RD_LAT-1:0] pipe_r;
   logic [RD_LAT-1:0] pipe_nxt_s;
   logic [OCC_W-1:0]  occ_s;
   logic [WIDTH-1:0]  head_s;
   logic              full_s;
   logic              skid_empty_s;
   logic              pop_s;
   logic              read_s;
   int                inflight_s;
   int                free_s;

   logic              proto_err_r;
   logic [CNT_W-1:0]  word_cnt_r;
   chk_state_e        chk_state_r;
   chk_state_e        chk_state_nxt_s;
   logic [WIDTH-1:0]  exp_r;
   logic [WIDTH-1:0]  exp_nxt_s;
   logic              seq_err_r;
   logic              seq_err_nxt_s;

   // Credit: a read is issued only if a skid slot is guaranteed for its data.
   always_comb begin
      inflight_s = 0;
      for (int i = 0; i < RD_LAT; i++) begin
         inflight_s = inflight_s + int'(pipe_r[i]);
      end
      free_s = SKID_DEPTH - int'(occ_s) - inflight_s;
      read_s = ~bus.empty_i & (free_s > 0);
   end

   // Next value of the issued-read shift pipe; the tail marks expected data.
   always_comb begin
      pipe_nxt_s    = {RD_LAT{1'b0}};
      pipe_nxt_s[0] = read_s;
      for (int i = 1; i < RD_LAT; i++) begin
         pipe_nxt_s[i] = pipe_r[i-1];
      end
   end

   // Issued-read pipe register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pipe_r <= {RD_LAT{1'b0}};
      end else begin
         pipe_r <= pipe_nxt_s;
      end
   end

   fifo_rd_skid #(
      .WIDTH (WIDTH),
      .DEPTH (SKID_DEPTH)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .push      (bus.out_vld_i),
      .push_data (bus.out_data_i),
      .pop       (pop_s),
      .head      (head_s),
      .occ       (occ_s),
      .full      (full_s),
      .empty     (skid_empty_s)
   );

   assign pop_s = ~skid_empty_s & bus.m_rdy_i;

   // Sticky protocol error: unexpected data, or data arriving with the skid full.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         proto_err_r <= 1'b0;
      end else if (bus.out_vld_i & (~pipe_r[RD_LAT-1] | full_s)) begin
         proto_err_r <= 1'b1;
      end else begin
         proto_err_r <= proto_err_r;
      end
   end

   // Delivered-word counter, wraps naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word_cnt_r <= {CNT_W{1'b0}};
      end else if (pop_s) begin
         word_cnt_r <= word_cnt_r + CNT_W'(1'b1);
      end else begin
         word_cnt_r <= word_cnt_r;
      end
   end

   // Checker next state: arm on first pop, then compare each popped word.
   always_comb begin
      chk_state_nxt_s = chk_state_r;
      exp_nxt_s       = exp_r;
      seq_err_nxt_s   = seq_err_r;
      if (!chk_en_i) begin
         chk_state_nxt_s = CHK_IDLE;
      end else begin
         case (chk_state_r)
            CHK_IDLE: begin
               if (pop_s) begin
                  exp_nxt_s       = head_s + WIDTH'(1'b1);
                  chk_state_nxt_s = CHK_TRACK;
               end else begin
                  chk_state_nxt_s = CHK_IDLE;
               end
            end
            CHK_TRACK: begin
               if (pop_s) begin
                  if (head_s != exp_r) begin
                     seq_err_nxt_s = 1'b1;
                  end else begin
                     seq_err_nxt_s = seq_err_r;
                  end
                  exp_nxt_s = head_s + WIDTH'(1'b1);
               end else begin
                  exp_nxt_s = exp_r;
               end
            end
            default: begin
               chk_state_nxt_s = CHK_IDLE;
            end
         endcase
      end
   end

   // Checker state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         chk_state_r <= CHK_IDLE;
         exp_r       <= {WIDTH{1'b0}};
         seq_err_r   <= 1'b0;
      end else begin
         chk_state_r <= chk_state_nxt_s;
         exp_r       <= exp_nxt_s;
         seq_err_r   <= seq_err_nxt_s;
      end
   end

   assign bus.read_o   = read_s;
   assign bus.m_vld_o  = ~skid_empty_s;
   assign bus.m_data_o = head_s;
   assign seq_err_o    = seq_err_r;
   assign proto_err_o  = proto_err_r;
   assign word_cnt_o   = word_cnt_r;

endmodule

// File: tb/tb_fifo_rd_port.sv
// Directed bench for fifo_rd_port with a small fifo model behind the read side.
module tb_fifo_rd_port;

   localparam int W      = 6;
   localparam int RD_LAT = 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        chk_en;
   logic        seq_err;
   logic        proto_err;
   logic [15:0] word_cnt;

   int errors = 0;
   int checks = 0;

   logic [W-1:0] q[$];
   logic [W-1:0] got[$];
   logic         pend_v [RD_LAT];
   logic [W-1:0] pend_d [RD_LAT];
   logic         stall_prev;
   logic [W-1:0] stall_data;
   logic         last_pop_v;
   logic [W-1:0] last_pop_d;

   fifo_rd_port_if #(.WIDTH(W)) bus ();

   fifo_rd_port #(.WIDTH(W), .RD_LAT(RD_LAT), .SKID_DEPTH(2), .CNT_W(16)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .chk_en_i    (chk_en),
      .seq_err_o   (seq_err),
      .proto_err_o (proto_err),
      .word_cnt_o  (word_cnt)
   );

   always #5 clk = ~clk;

   task automatic clear_model();
      q.delete();
      got.delete();
      for (int i = 0; i < RD_LAT; i++) begin
         pend_v[i] = 1'b0;
         pend_d[i] = '0;
      end
      stall_prev     = 1'b0;
      last_pop_v     = 1'b0;
      bus.empty_i    = 1'b1;
      bus.out_vld_i  = 1'b0;
      bus.out_data_i = '0;
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      chk_en     = 1'b0;
      bus.m_rdy_i = 1'b0;
      clear_model();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // One clock: sample before the edge, then advance the fifo model.
   task automatic step();
      logic         rd, pv, hit;
      logic [W-1:0] pd, nd;
      #1;
      rd = bus.read_o;
      pv = bus.m_vld_o & bus.m_rdy_i;
      pd = bus.m_data_o;
      if (stall_prev) begin
         checks++;
         if (bus.m_vld_o !== 1'b1 || bus.m_data_o !== stall_data) begin
            errors++;
            $display("FAIL stall_hold: vld=%b data=%0d required vld=1 data=%0d",
                     bus.m_vld_o, bus.m_data_o, stall_data);
         end
      end
      stall_prev = bus.m_vld_o & ~bus.m_rdy_i;
      stall_data = bus.m_data_o;
      @(posedge clk);
      #1;
      last_pop_v = pv;
      last_pop_d = pd;
      if (pv) got.push_back(pd);
      hit = rd && (q.size() > 0);
      nd  = '0;
      if (hit) nd = q.pop_front();
      for (int i = RD_LAT - 1; i > 0; i--) begin
         pend_v[i] = pend_v[i-1];
         pend_d[i] = pend_d[i-1];
      end
      pend_v[0]      = hit;
      pend_d[0]      = nd;
      bus.out_vld_i  = pend_v[RD_LAT-1];
      bus.out_data_i = pend_d[RD_LAT-1];
      bus.empty_i    = (q.size() == 0);
   endtask

   task automatic drain(input int n, input int budget, input bit toggle);
      int k = 0;
      while ((got.size() < n) && (k < budget)) begin
         if (toggle) bus.m_rdy_i = ~bus.m_rdy_i;
         step();
         k++;
      end
   endtask

   task automatic test_reset();
      do_reset();
      repeat (10) step();
      checks++; if (bus.read_o !== 1'b0) begin errors++; $display("FAIL reset_read: got %b want 0", bus.read_o); end
      checks++; if (bus.m_vld_o !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", bus.m_vld_o); end
      checks++; if (bus.m_data_o !== 6'd0) begin errors++; $display("FAIL reset_data: got %0d want 0", bus.m_data_o); end
      checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL reset_seq_err: got %b want 0", seq_err); end
      checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err: got %b want 0", proto_err); end
      checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL reset_word_cnt: got %0d want 0", word_cnt); end
   endtask

   task automatic test_stream(input bit toggle, input string tag);
      int bad = 0;
      do_reset();
      chk_en      = 1'b1;
      bus.m_rdy_i = 1'b1;
      for (int i = 0; i < 64; i++) q.push_back(i[W-1:0]);
      bus.empty_i = 1'b0;
      if (!toggle) begin
         step();
         checks++; if (bus.m_vld_o !== 1'b0) begin errors++; $display("FAIL %s_lat1: vld=%b want 0", tag, bus.m_vld_o); end
         step();
         checks++; if (bus.m_vld_o !== 1'b1 || bus.m_data_o !== 6'd0) begin errors++; $display("FAIL %s_lat2: vld=%b data=%0d want 1/0", tag, bus.m_vld_o, bus.m_data_o); end
      end
      drain(64, 500, toggle);
      bus.m_rdy_i = 1'b1;
      repeat (3) step();
      for (int i = 0; i < got.size(); i++) if (got[i] !== i[W-1:0]) bad++;
      checks++; if (got.size() != 64) begin errors++; $display("FAIL %s_count: got %0d words want 64", tag, got.size()); end
      checks++; if (bad != 0) begin errors++; $display("FAIL %s_order: %0d words out of order want 0", tag, bad); end
      checks++; if (word_cnt !== 16'd64) begin errors++; $display("FAIL %s_word_cnt: got %0d want 64", tag, word_cnt); end
      checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL %s_seq_err: got %b want 0", tag, seq_err); end
      checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL %s_proto_err: got %b want 0", tag, proto_err); end
      checks++; if (bus.m_vld_o !== 1'b0 || bus.read_o !== 1'b0) begin errors++; $display("FAIL %s_idle: vld=%b read=%b want 0/0", tag, bus.m_vld_o, bus.read_o); end
   endtask

   task automatic test_seq_err();
      logic seen9 = 1'b0;
      int   k = 0;
      do_reset();
      chk_en      = 1'b1;
      bus.m_rdy_i = 1'b1;
      q.push_back(6'd5); q.push_back(6'd6); q.push_back(6'd7);
      q.push_back(6'd9); q.push_back(6'd10);
      bus.empty_i = 1'b0;
      while ((got.size() < 5) && (k < 60)) begin
         step();
         k++;
         if (last_pop_v && (last_pop_d == 6'd9)) seen9 = 1'b1;
         checks++; if (seq_err !== seen9) begin errors++; $display("FAIL seq_err_timing: cycle %0d got %b want %b", k, seq_err, seen9); end
      end
      checks++; if (got.size() != 5) begin errors++; $display("FAIL seq_count: got %0d words want 5", got.size()); end
      checks++; if (word_cnt !== 16'd5) begin errors++; $display("FAIL seq_word_cnt: got %0d want 5", word_cnt); end
      chk_en = 1'b0;
      repeat (2) step();
      checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL seq_err_retained: got %b want 1", seq_err); end
   endtask

   task automatic test_wrap();
      logic [W-1:0] exp_w [4];
      int bad = 0;
      exp_w[0] = 6'd62; exp_w[1] = 6'd63; exp_w[2] = 6'd0; exp_w[3] = 6'd1;
      do_reset();
      chk_en      = 1'b1;
      bus.m_rdy_i = 1'b1;
      for (int i = 0; i < 4; i++) q.push_back(exp_w[i]);
      bus.empty_i = 1'b0;
      drain(4, 60, 1'b0);
      for (int i = 0; i < got.size() && i < 4; i++) if (got[i] !== exp_w[i]) bad++;
      checks++; if (got.size() != 4 || bad != 0) begin errors++; $display("FAIL wrap_order: %0d words, %0d wrong, want 4/0", got.size(), bad); end
      checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL wrap_seq_err: got %b want 0", seq_err); end
   endtask

   task automatic test_proto();
      do_reset();
      repeat (2) step();
      bus.out_vld_i  = 1'b1;
      bus.out_data_i = 6'd33;
      @(posedge clk);
      #1 bus.out_vld_i = 1'b0;
      checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_set: got %b want 1", proto_err); end
      checks++; if (bus.m_vld_o !== 1'b1 || bus.m_data_o !== 6'd33) begin errors++; $display("FAIL proto_stored: vld=%b data=%0d want 1/33", bus.m_vld_o, bus.m_data_o); end
      do_reset();
      checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_clear: got %b want 0", proto_err); end
      checks++; if (bus.m_vld_o !== 1'b0) begin errors++; $display("FAIL proto_clear_vld: got %b want 0", bus.m_vld_o); end
   endtask

   task automatic test_reset_mid();
      int bad = 0;
      do_reset();
      bus.m_rdy_i = 1'b1;
      for (int i = 0; i < 10; i++) q.push_back(i[W-1:0]);
      bus.empty_i = 1'b0;
      repeat (4) step();
      bus.m_rdy_i = 1'b0;
      step();
      checks++; if (word_cnt !== 16'(got.size())) begin errors++; $display("FAIL mid_pre_cnt: got %0d want %0d", word_cnt, got.size()); end
      checks++; if (bus.m_vld_o !== 1'b1) begin errors++; $display("FAIL mid_pre_vld: got %b want 1", bus.m_vld_o); end
      #3 reset = 1'b1;
      #1;
      checks++; if (bus.m_vld_o !== 1'b0) begin errors++; $display("FAIL mid_async_vld: got %b want 0", bus.m_vld_o); end
      checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL mid_async_cnt: got %0d want 0", word_cnt); end
      clear_model();
      @(posedge clk);
      #1 reset = 1'b0;
      bus.m_rdy_i = 1'b1;
      q.push_back(6'd0); q.push_back(6'd1); q.push_back(6'd2);
      bus.empty_i = 1'b0;
      drain(3, 60, 1'b0);
      for (int i = 0; i < got.size() && i < 3; i++) if (got[i] !== i[W-1:0]) bad++;
      checks++; if (got.size() != 3 || bad != 0) begin errors++; $display("FAIL mid_restart: %0d words, %0d wrong, want 3/0", got.size(), bad); end
      checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL mid_proto: got %b want 0", proto_err); end
      checks++; if (word_cnt !== 16'd3) begin errors++; $display("FAIL mid_word_cnt: got %0d want 3", word_cnt); end
   endtask

   initial begin
      reset       = 1'b1;
      chk_en      = 1'b0;
      bus.m_rdy_i = 1'b0;
      clear_model();
      test_reset();
      test_stream(1'b0, "stream");
      test_stream(1'b1, "stall");
      test_seq_err();
      test_wrap();
      test_proto();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
